// File: rtl/display_pkg.sv
// Shared types and constants for the BCD scan display path.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } conv_state_t;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_scan_driver_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter; out-of-range values
// saturate to all nines and flag overflow at commit.
module bin2bcd
    import display_pkg::*;
#(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned NDIG  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic [4*NDIG-1:0]   bcd,
    output logic                ovf,
    output logic                commit
);

    localparam longint unsigned MAX = pow10(NDIG) - 1;
    localparam int unsigned     CW  = $clog2(WIDTH + 1);

    conv_state_t       state_q;
    logic [WIDTH-1:0]  bin_q;
    logic [4*NDIG-1:0] shadow_q;
    logic [4*NDIG-1:0] adj_d;
    logic [CW-1:0]     cnt_q;
    logic              pend_q;
    logic              too_big;

    assign too_big = 64'(value) > MAX;

    // Nibble-local +3 correction; no carries cross digit boundaries.
    always_comb begin
        adj_d = shadow_q;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (shadow_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = shadow_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load) begin
                        if (too_big) begin
                            shadow_q <= {NDIG{4'd9}};
                            pend_q   <= 1'b1;
                            state_q  <= COMMIT;
                        end else begin
                            bin_q    <= value;
                            shadow_q <= '0;
                            cnt_q    <= '0;
                            state_q  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    {shadow_q, bin_q} <= {adj_d, bin_q} << 1;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= COMMIT;
                    end
                end
                COMMIT: begin
                    pend_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign commit = (state_q == COMMIT);
    assign bcd    = shadow_q;
    assign ovf    = pend_q;

endmodule

// File: rtl/bcd_scan_driver.sv
// Binary-to-decimal display driver: converts on request, then scans the
// committed digits one at a time with leading-zero blanking.
module bcd_scan_driver
    import display_pkg::*;
#(
    parameter int unsigned WIDTH    = 14,
    parameter int unsigned NDIG     = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             overflow,
    output logic [3:0]       digit,
    output logic [NDIG-1:0]  dig_sel
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [4*NDIG-1:0] bcd;
    logic [4*NDIG-1:0] disp_q;
    logic              conv_ovf;
    logic              commit;
    logic              overflow_q;
    logic [PW-1:0]     pre_q;
    logic [IW-1:0]     idx_q;
    logic              blank;
    logic [3:0]        digit_d;
    logic [3:0]        digit_q;
    logic [NDIG-1:0]   sel_d;
    logic [NDIG-1:0]   sel_q;

    bin2bcd #(
        .WIDTH (WIDTH),
        .NDIG  (NDIG)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .value  (value),
        .busy   (busy),
        .bcd    (bcd),
        .ovf    (conv_ovf),
        .commit (commit)
    );

    // Visible value only moves on commit, so a conversion never shows partial digits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else if (commit) begin
            disp_q     <= bcd;
            overflow_q <= conv_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_q <= '0;
            idx_q <= (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            pre_q <= pre_q + PW'(1);
        end
    end

    always_comb begin
        blank   = (idx_q != '0);
        digit_d = 4'd0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (IW'(i) >= idx_q && disp_q[4*i +: 4] != 4'd0) begin
                blank = 1'b0;
            end
            if (IW'(i) == idx_q) begin
                digit_d = disp_q[4*i +: 4];
            end
        end
        sel_d = NDIG'(1) << idx_q;
        if (blank) begin
            digit_d = 4'd0;
            sel_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_q <= '0;
            sel_q   <= '0;
        end else begin
            digit_q <= digit_d;
            sel_q   <= sel_d;
        end
    end

    assign overflow = overflow_q;
    assign digit    = digit_q;
    assign dig_sel  = sel_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed plus randomized bench for bcd_scan_driver, compared every cycle
// against a decimal-arithmetic reference model.
module tb_bcd_scan_driver;

    localparam int unsigned WIDTH    = 14;
    localparam int unsigned NDIG     = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned MAX      = 9999;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             load  = 1'b0;
    logic [WIDTH-1:0] value = '0;
    logic             busy;
    logic             overflow;
    logic [3:0]       digit;
    logic [NDIG-1:0]  dig_sel;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    bcd_scan_driver #(
        .WIDTH    (WIDTH),
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .busy     (busy),
        .overflow (overflow),
        .digit    (digit),
        .dig_sel  (dig_sel)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    function automatic int unsigned p10(input int unsigned n);
        int unsigned r = 1;
        for (int unsigned i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // Reference model: tracks the shown decimal number, remaining busy cycles
    // and elapsed scan time, deriving outputs with division and modulo.
    bit          m_valid = 1'b0;
    int unsigned m_edges, m_left, m_disp, m_next, m_pos;
    bit          m_ovf, m_next_ovf;
    int unsigned exp_sel, exp_dig;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_edges = 0;
            m_left  = 0;
            m_disp  = 0;
            m_ovf   = 1'b0;
            exp_sel = 0;
            exp_dig = 0;
        end else if (m_valid) begin
            m_pos = (m_edges / SCAN_DIV) % NDIG;
            if (m_pos > 0 && m_disp < p10(m_pos)) begin
                exp_sel = 0;
                exp_dig = 0;
            end else begin
                exp_sel = 1 << m_pos;
                exp_dig = (m_disp / p10(m_pos)) % 10;
            end
            m_edges++;
            if (m_left == 0) begin
                if (load) begin
                    if (value > MAX) begin
                        m_left = 1; m_next = MAX; m_next_ovf = 1'b1;
                    end else begin
                        m_left = WIDTH + 1; m_next = value; m_next_ovf = 1'b0;
                    end
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_disp = m_next;
                    m_ovf  = m_next_ovf;
                end
            end
        end
        if (m_valid) begin
            #1;
            check_eq("busy",     busy,     (m_left != 0) ? 1 : 0);
            check_eq("overflow", overflow, m_ovf ? 1 : 0);
            check_eq("dig_sel",  dig_sel,  exp_sel);
            check_eq("digit",    digit,    exp_dig);
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input int unsigned v);
        load  = 1'b1;
        value = WIDTH'(v);
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic busy_len(input string tag, input int unsigned exp);
        int unsigned k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, k, exp);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        while (busy && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, busy, 0);
    endtask

    initial begin
        int unsigned r, v;
        step(2);
        rst_n = 1'b1;
        step(20);

        do_load(1234);
        busy_len("busy_len_1234", WIDTH + 1);
        step(20);

        do_load(7);
        wait_idle("idle_7");
        step(18);
        do_load(0);
        wait_idle("idle_0");
        step(18);

        do_load(12000);
        busy_len("busy_len_ovf", 1);
        step(18);
        do_load(42);
        wait_idle("idle_42");
        step(18);

        do_load(1234);
        step(3);
        do_load(5555);
        wait_idle("idle_drop");
        step(18);

        do_load(1234);
        step(4);
        rst_n = 1'b0;
        step(1);
        check_eq("rst_mid_busy", busy, 0);
        rst_n = 1'b1;
        step(2);
        do_load(9);
        wait_idle("idle_9");
        step(18);

        load = 1'b1;
        for (int i = 0; i < 40; i++) begin
            value = WIDTH'($urandom_range(0, 16383));
            @(negedge clk);
        end
        load = 1'b0;
        wait_idle("idle_b2b");

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 20) begin
                case ($urandom_range(0, 2))
                    0:       v = $urandom_range(0, 16383);
                    1:       v = $urandom_range(0, 99);
                    default: v = $urandom_range(9990, 10010);
                endcase
                do_load(v);
            end else if (r == 99) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end else begin
                step(1);
            end
        end
        wait_idle("idle_final");
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Converts a binary value to decimal and time-multiplexes its digits onto a single seven-segment decoder. Sits directly upstream of the 4-bit-in, segment-out `display` decoder: `digit` feeds the decoder's `data` input, and `dig_sel` drives the digit enables of a multi-digit display. Conversion is a sequential shift-add-3 (double-dabble). The visible digits update atomically, only after a conversion completes.

## Interface
- `WIDTH`, 14: binary input width.
- `NDIG`, 4: number of display digits.
- `SCAN_DIV`, 50000: clock cycles each digit stays selected; must be ≥ 2.
- `clk` in, 1: single clock; everything is rising-edge.
- `rst_n` in, 1: reset, synchronous, active-low.
- `load` in, 1: request a conversion of `value`; sampled only in IDLE.
- `value` in, WIDTH: unsigned binary operand, captured on an accepted `load`.
- `busy` out, 1: conversion in progress; `load` is ignored while high.
- `overflow` out, 1: last committed value exceeded 10^NDIG−1.
- `digit` out, 4: BCD nibble of the selected digit, always 0–9; goes to the decoder's `data`.
- `dig_sel` out, NDIG: one-hot, active-high digit enable; bit 0 is the least-significant digit.

## Operation
- Converter FSM has three states: IDLE, SHIFT, COMMIT. `busy = (state != IDLE)`.
- **IDLE, `load` = 1, `value` ≤ MAX** (MAX = 10^NDIG−1):
  - capture `value` into the shift register;
  - clear the 4·NDIG-bit BCD shadow;
  - set bit counter = 0; go to SHIFT.
- **IDLE, `load` = 1, `value` > MAX:**
  - shadow = all nibbles 9;
  - overflow-pending = 1;
  - go straight to COMMIT.
- **SHIFT, each cycle:**
  - every shadow nibble ≥ 5 gets +3, with no carry between nibbles;
  - then {shadow, binary} shifts left by 1, MSB of binary entering the shadow LSB;
  - counter increments; after WIDTH shift cycles, go to COMMIT.
- **COMMIT:**
  - display register ← shadow;
  - `overflow` ← overflow-pending, then pending clears;
  - go to IDLE.
- The display register changes only in COMMIT. The old value stays visible for the whole conversion.
- `load` while busy is dropped, not queued.
- **Scan:**
  - prescaler counts 0..SCAN_DIV−1 and wraps;
  - on wrap, digit index advances 0→NDIG−1→0.
- **Leading-zero blanking:**
  - index i > 0 is blanked when the display-register nibbles NDIG−1 down to i are all zero;
  - a blanked digit gets `dig_sel` = 0 and `digit` = 0;
  - index 0 is never blanked, so zero displays as "0".
- `digit` and `dig_sel` are registered from the index and the display register.

## Timing
- **Reset** (`rst_n` = 0 at an edge): state IDLE, `busy` 0, `overflow` 0, display register 0, prescaler 0, index 0, `digit` 0, `dig_sel` 0. The first cycle after reset release gives `dig_sel` = 1 and `digit` = 0.
- **Reset mid-conversion:** aborts; the shadow is discarded and the display register is 0.
- **Normal latency:** `load` accepted at edge 0 → `busy` high for WIDTH+1 cycles (SHIFT ×WIDTH, COMMIT ×1). The display register is new after edge WIDTH+1. `digit`/`dig_sel` reflect it one edge later.
- **Overflow latency:** `busy` is high for 1 cycle (COMMIT only).
- **Back-to-back loads:** `load` held high is accepted again in the first IDLE cycle after COMMIT.
- **Output lag:** `dig_sel`/`digit` change exactly one cycle after an index change. Each digit is held SCAN_DIV cycles.

## Structure
- Package `display_pkg`:
  - state enum `conv_state_t` {IDLE, SHIFT, COMMIT};
  - constant function `pow10(n)`, used for MAX as a localparam.
- Sub-module `bin2bcd` holds the converter FSM:
  - inputs `load`/`value`; outputs `busy`, `bcd` (4·NDIG), `ovf`, one-cycle `commit` pulse.
- The top level contains the display register, prescaler, index, blanking and output registers.

## Test plan
- **Reset:** release reset → `busy` = 0, `overflow` = 0. Next cycle `dig_sel` = 0001, `digit` = 0. Other digits stay blanked throughout.
- **Nominal conversion** (SCAN_DIV = 4): load 1234 → `busy` high exactly 15 cycles. Then `dig_sel`/`digit` cycle 0001/4, 0010/3, 0100/2, 1000/1, each 4 cycles.
- **Leading-zero blanking:** load 7 → only the 0001 slot asserts with `digit` = 7. Slots 1–3 give `dig_sel` = 0000, `digit` = 0. Load 0 → same pattern with `digit` = 0.
- **Overflow:** load 12000 → `busy` high 1 cycle, `overflow` = 1, digits 9,9,9,9. Then load 42 → `overflow` = 0, display shows 42.
- **Dropped load:** load 1234, then pulse load 5555 during SHIFT → 5555 is ignored, 1234 is displayed, and the old value stays visible until COMMIT.
- **Reset mid-conversion:** load 1234, assert `rst_n` = 0 at SHIFT cycle 5 → `busy` = 0 and display register = 0 after that edge. A following load 9 converts normally.
